// File: rtl/qdram_pkg.sv
// qdram_pkg: shared state encodings and scroll/mode register constants for qbus_dram_ctl.
package qdram_pkg;
  typedef enum logic [1:0] {B_IDLE, B_ADDR, B_REQ, B_RPLY} bus_st_e;
  typedef enum logic [2:0] {D_IDLE, D_RAS, D_COL, D_PRE, D_REF} dram_st_e;
  localparam logic [15:0] REG_RST  = 16'o001330;
  localparam logic [15:0] REG_MASK = 16'o001377;
endpackage

// File: rtl/qdram_refresh.sv
// qdram_refresh: refresh interval timer with a saturating pending flag cleared by the DRAM FSM.
module qdram_refresh #(
  parameter int REF_DIV = 94
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ack,
  output logic o_req
);
  localparam int TW = $clog2(REF_DIV + 1);
  logic [TW-1:0] r_tmr;
  logic          w_tick;
  assign w_tick = r_tmr == '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tmr <= TW'(REF_DIV);
      o_req <= 1'b0;
    end else begin
      r_tmr <= w_tick ? TW'(REF_DIV) : r_tmr - TW'(1);
      o_req <= w_tick | (o_req & ~i_ack);
    end
endmodule

// File: rtl/qbus_dram_ctl.sv
// qbus_dram_ctl: Q-bus slave mapping a RAM window onto multiplexed DRAM, with CBR refresh and a scroll/mode register.
// Define QDRAM_WTBT_EN to honour nWTBT byte writes; otherwise every write is a word write.
module qbus_dram_ctl
  import qdram_pkg::*;
#(
  parameter int          ADDR_W   = 7,
  parameter int unsigned MEM_TOP  = 32'o100000,
  parameter logic [15:0] REG_ADDR = 16'o177664,
  parameter int          REF_DIV  = 94,
  parameter int          CAS_CLK  = 2,
  parameter int          T_RP     = 2
) (
  input  logic              PIN_CLK,
  input  logic              PIN_nR,
  input  logic [15:0]       PIN_nAD_in,
  output logic [15:0]       PIN_nAD_out,
  output logic              PIN_AD_oe,
  input  logic              PIN_nSYNC,
  input  logic              PIN_nDIN,
  input  logic              PIN_nDOUT,
  input  logic              PIN_nWTBT,
  output logic              PIN_nRPLY,
  output logic [ADDR_W-1:0] PIN_A,
  output logic              PIN_nRAS,
  output logic [1:0]        PIN_nCAS,
  output logic              PIN_nWE,
  input  logic [15:0]       PIN_DI,
  output logic [15:0]       PIN_DO,
  output logic [7:0]        PIN_SCROLL,
  output logic              PIN_FULL
);
  logic [1:0]        r_nsync_q, r_ndin_q, r_ndout_q;
  logic [15:0]       r_addr, r_reg;
  logic              r_wr, r_isreg, r_dwr;
  logic [1:0]        r_lanes;
  logic [7:0]        r_dcnt;
  logic [ADDR_W-1:0] r_col;
  bus_st_e           r_bst;
  dram_st_e          r_dst;
  logic              w_nsync, w_ndin, w_ndout, w_ram, w_reg, w_dreq, w_last, w_done, w_launch;
  logic              w_ref_req, w_ref_ack;
  logic [ADDR_W-1:0] w_row, w_col;
  logic [1:0]        w_lanes;
  logic [15:0]       w_wmask;
  assign w_nsync    = r_nsync_q[1];
  assign w_ndin     = r_ndin_q[1];
  assign w_ndout    = r_ndout_q[1];
  assign w_ram      = 32'(r_addr) < MEM_TOP;
  assign w_reg      = r_addr[15:1] == REG_ADDR[15:1];
  assign w_row      = ADDR_W'(r_addr >> 1);
  assign w_col      = ADDR_W'(r_addr >> (ADDR_W + 1));
  assign w_dreq     = (r_bst == B_REQ) & ~r_isreg;
  assign PIN_SCROLL = r_reg[7:0];
  assign PIN_FULL   = r_reg[9];
`ifdef QDRAM_WTBT_EN
  logic r_byte;
  always_ff @(posedge PIN_CLK or negedge PIN_nR)
    if (!PIN_nR) r_byte <= 1'b0;
    else if (r_bst == B_ADDR) r_byte <= ~PIN_nWTBT & ~w_ndout;
  assign w_lanes = r_byte ? (r_addr[0] ? 2'b01 : 2'b10) : 2'b00;
  assign w_wmask = r_byte ? (r_addr[0] ? 16'o001000 : 16'o000377) : REG_MASK;
`else
  logic w_unused;
  assign w_unused = PIN_nWTBT;
  assign w_lanes  = 2'b00;
  assign w_wmask  = REG_MASK;
`endif
  qdram_refresh #(.REF_DIV(REF_DIV)) u_ref (
    .i_clk   (PIN_CLK),
    .i_rst_n (PIN_nR),
    .i_ack   (w_ref_ack),
    .o_req   (w_ref_req)
  );
  always_ff @(posedge PIN_CLK or negedge PIN_nR)
    if (!PIN_nR) begin
      r_nsync_q   <= 2'b11;
      r_ndin_q    <= 2'b11;
      r_ndout_q   <= 2'b11;
      r_addr      <= '0;
      r_reg       <= REG_RST;
      r_wr        <= 1'b0;
      r_isreg     <= 1'b0;
      r_bst       <= B_IDLE;
      PIN_DO      <= '0;
      PIN_nRPLY   <= 1'b1;
      PIN_AD_oe   <= 1'b0;
      PIN_nAD_out <= '1;
    end else begin
      r_nsync_q <= {r_nsync_q[0], PIN_nSYNC};
      r_ndin_q  <= {r_ndin_q[0], PIN_nDIN};
      r_ndout_q <= {r_ndout_q[0], PIN_nDOUT};
      if (PIN_nSYNC) r_addr <= ~PIN_nAD_in;
      case (r_bst)
        B_IDLE: if (!w_nsync) r_bst <= B_ADDR;
        B_ADDR:
          if (w_nsync) r_bst <= B_IDLE;
          else if ((w_ram | w_reg) & ~(w_ndin & w_ndout)) begin
            r_bst   <= B_REQ;
            r_wr    <= ~w_ndout;
            r_isreg <= w_reg;
            PIN_DO  <= ~PIN_nAD_in;
          end
        B_REQ:
          if (w_nsync) r_bst <= B_IDLE;
          else if (r_isreg | w_done) begin
            r_bst       <= B_RPLY;
            PIN_nRPLY   <= 1'b0;
            PIN_AD_oe   <= ~r_wr;
            PIN_nAD_out <= r_wr ? '1 : r_isreg ? ~r_reg : ~PIN_DI;
            if (r_isreg & r_wr) r_reg <= (r_reg & ~w_wmask) | (PIN_DO & w_wmask);
          end
        B_RPLY:
          if (w_nsync & w_ndin & w_ndout) begin
            r_bst       <= B_IDLE;
            PIN_nRPLY   <= 1'b1;
            PIN_AD_oe   <= 1'b0;
            PIN_nAD_out <= '1;
          end
        default: r_bst <= B_IDLE;
      endcase
    end
  // Last precharge clock launches the next cycle directly so back-to-back work skips IDLE.
  assign w_last    = r_dcnt == ((r_dst == D_COL) ? 8'(CAS_CLK - 1) : (r_dst == D_PRE) ? 8'(T_RP - 1) :
                                (r_dst == D_REF) ? 8'd2 : 8'd0);
  assign w_done    = (r_dst == D_COL) & w_last;
  assign w_ref_ack = (r_dst == D_REF) & w_last;
  assign w_launch  = (r_dst == D_IDLE) | ((r_dst == D_PRE) & w_last);
  always_ff @(posedge PIN_CLK or negedge PIN_nR)
    if (!PIN_nR) begin
      r_dst    <= D_IDLE;
      r_dcnt   <= '0;
      r_col    <= '0;
      r_dwr    <= 1'b0;
      r_lanes  <= 2'b00;
      PIN_A    <= '0;
      PIN_nRAS <= 1'b1;
      PIN_nCAS <= 2'b11;
      PIN_nWE  <= 1'b1;
    end else begin
      r_dcnt <= (w_launch | w_last) ? '0 : r_dcnt + 8'd1;
      if (w_launch) begin
        if (w_ref_req) begin
          r_dst    <= D_REF;
          PIN_nCAS <= 2'b00;
        end else if (w_dreq) begin
          r_dst    <= D_RAS;
          PIN_nRAS <= 1'b0;
          PIN_A    <= w_row;
          r_col    <= w_col;
          r_dwr    <= r_wr;
          r_lanes  <= w_lanes;
        end else r_dst <= D_IDLE;
      end else if (w_last) begin
        case (r_dst)
          D_RAS: begin
            r_dst    <= D_COL;
            PIN_A    <= r_col;
            PIN_nCAS <= r_lanes;
            PIN_nWE  <= ~r_dwr;
          end
          D_COL, D_REF: begin
            r_dst    <= D_PRE;
            PIN_nRAS <= 1'b1;
            PIN_nCAS <= 2'b11;
            PIN_nWE  <= 1'b1;
          end
          default: r_dst <= D_IDLE;
        endcase
      end else if (r_dst == D_REF) PIN_nRAS <= 1'b0;
    end
endmodule

// File: tb/tb_qbus_dram_ctl.sv
// tb_qbus_dram_ctl: directed Q-bus cycles against a behavioural DRAM, checked against hand-computed values.
module tb_qbus_dram_ctl;
  localparam int REF_DIV = 94;
  localparam int CAS_CLK = 2;
  localparam int T_RP    = 2;
  logic        clk = 1'b0, nr = 1'b0;
  logic [15:0] nad_in = '1, nad_out, di, pdo;
  logic        ad_oe, nsync = 1'b1, ndin = 1'b1, ndout = 1'b1, nwtbt = 1'b1;
  logic        nrply, nras, nwe, full;
  logic [6:0]  a, m_row;
  logic [1:0]  ncas;
  logic [7:0]  scroll;
  logic [15:0] mem [0:16383];
  int          n_vec = 0, n_err = 0, cyc;
  always #5 clk = ~clk;
  qbus_dram_ctl #(
    .ADDR_W(7), .MEM_TOP(32'o100000), .REG_ADDR(16'o177664),
    .REF_DIV(REF_DIV), .CAS_CLK(CAS_CLK), .T_RP(T_RP)
  ) dut (
    .PIN_CLK(clk), .PIN_nR(nr), .PIN_nAD_in(nad_in), .PIN_nAD_out(nad_out), .PIN_AD_oe(ad_oe),
    .PIN_nSYNC(nsync), .PIN_nDIN(ndin), .PIN_nDOUT(ndout), .PIN_nWTBT(nwtbt), .PIN_nRPLY(nrply),
    .PIN_A(a), .PIN_nRAS(nras), .PIN_nCAS(ncas), .PIN_nWE(nwe), .PIN_DI(di), .PIN_DO(pdo),
    .PIN_SCROLL(scroll), .PIN_FULL(full)
  );
  always @(posedge clk or negedge nr)
    if (!nr) cyc <= 0;
    else cyc <= cyc + 1;
  // Behavioural DRAM: row captured while RAS is low ahead of CAS, lane writes while CAS and WE are low.
  assign di = mem[{a, m_row}];
  always @(negedge clk)
    if (!nras) begin
      if (ncas == 2'b11) m_row <= a;
      else if (!nwe) begin
        if (!ncas[0]) mem[{a, m_row}][7:0] <= pdo[7:0];
        if (!ncas[1]) mem[{a, m_row}][15:8] <= pdo[15:8];
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o, expected %0o", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    nr = 1'b0; nsync = 1'b1; ndin = 1'b1; ndout = 1'b1; nwtbt = 1'b1; nad_in = '1;
    repeat (4) @(negedge clk);
    chk("rst_nras", nras, 1);
    chk("rst_ncas", ncas, 2'b11);
    chk("rst_nrply", nrply, 1);
    chk("rst_scroll", scroll, 8'o330);
    chk("rst_full", full, 1);
    nr = 1'b1;
  endtask
  // lat counts clocks from driving DIN/DOUT until nRPLY is seen low; -1 when no reply within 64.
  task automatic bus(input logic [15:0] addr, input logic [15:0] data, input bit wr, input bit byt,
                     input int at_cyc, output logic [15:0] rd, output int lat, output logic [6:0] row,
                     output logic [1:0] lanes, output bit we_seen, output logic oe);
    bit acc;
    @(negedge clk);
    nsync = 1'b1; nad_in = ~addr;
    repeat (2) @(negedge clk);
    nsync = 1'b0;
    @(negedge clk);
    while (cyc < at_cyc) @(negedge clk);
    if (wr) begin
      nad_in = ~data; nwtbt = ~byt; ndout = 1'b0;
    end else begin
      nad_in = '1; ndin = 1'b0;
    end
    lat = 0; acc = 0; row = '0; lanes = 2'b11; we_seen = 0;
    while (lat < 64 && nrply) begin
      @(posedge clk); #1;
      lat++;
      if (!nras && ncas == 2'b11 && !acc) begin
        acc = 1; row = a;
      end else if (acc && ncas != 2'b11) begin
        lanes &= ncas; we_seen |= !nwe;
      end
    end
    if (nrply) lat = -1;
    rd = ~nad_out; oe = ad_oe;
    @(negedge clk);
    nsync = 1'b1; ndin = 1'b1; ndout = 1'b1; nwtbt = 1'b1; nad_in = '1;
    for (int i = 0; i < 8 && !nrply; i++) @(negedge clk);
    chk("rply_release", nrply, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] rd;
    int          lat, cbr, rar;
    logic [6:0]  row;
    logic [1:0]  ln, pc;
    bit          we;
    logic        oe, pr;
    do_reset();
    bus(16'o000000, 16'o000001, 1, 0, 0, rd, lat, row, ln, we, oe);
    chk("w0_lat", lat, 2 + 3 + CAS_CLK);
    chk("w0_row", row, 0);
    chk("w0_lanes", ln, 2'b00);
    chk("w0_we", we, 1);
    bus(16'o000010, 16'o000015, 1, 0, 0, rd, lat, row, ln, we, oe);
    chk("w10_row", row, 4);
    bus(16'o000000, 16'o0, 0, 0, 0, rd, lat, row, ln, we, oe);
    chk("r0_data", rd, 16'o000001);
    chk("r0_oe", oe, 1);
    chk("r0_we", we, 0);
    bus(16'o000010, 16'o0, 0, 0, 0, rd, lat, row, ln, we, oe);
    chk("r10_data", rd, 16'o000015);
    chk("r10_row", row, 4);
    bus(16'o177664, 16'o177777, 1, 0, 0, rd, lat, row, ln, we, oe);
    chk("reg_w_scroll", scroll, 8'o377);
    chk("reg_w_full", full, 1);
    bus(16'o177664, 16'o0, 0, 0, 0, rd, lat, row, ln, we, oe);
    chk("reg_r_data", rd, 16'o001377);
    bus(16'o177665, 16'o000330, 1, 0, 0, rd, lat, row, ln, we, oe);
    chk("reg_w2_scroll", scroll, 8'o330);
    chk("reg_w2_full", full, 0);
    bus(16'o100000, 16'o0, 0, 0, 0, rd, lat, row, ln, we, oe);
    chk("unmap_no_rply", lat, -1);
    bus(16'o000000, 16'o0, 0, 0, 0, rd, lat, row, ln, we, oe);
    chk("after_unmap_rply", lat > 0, 1);
    chk("after_unmap_data", rd, 16'o000001);
    bus(16'o000001, 16'h5A00, 1, 1, 0, rd, lat, row, ln, we, oe);
`ifdef QDRAM_WTBT_EN
    chk("byte_lanes", ln, 2'b01);
`else
    chk("byte_lanes", ln, 2'b00);
`endif
    bus(16'o000000, 16'o0, 0, 0, 0, rd, lat, row, ln, we, oe);
`ifdef QDRAM_WTBT_EN
    chk("byte_data", rd, 16'h5A01);
`else
    chk("byte_data", rd, 16'h5A00);
`endif
    do_reset();
    cbr = 0; rar = 0; pc = 2'b11; pr = 1'b1;
    for (int i = 0; i < REF_DIV + 10; i++) begin
      @(posedge clk); #1;
      if (ncas == 2'b00 && nras) cbr++;
      if (!nras && pc == 2'b00 && pr) rar++;
      pc = ncas; pr = nras;
    end
    chk("cbr_cas_first", cbr, 1);
    chk("cbr_ras_after", rar, 1);
    do_reset();
    bus(16'o000010, 16'o0, 0, 0, REF_DIV - 2, rd, lat, row, ln, we, oe);
    chk("ref_first_lat", lat, 2 + 6 + CAS_CLK + T_RP);
    chk("ref_first_data", rd, 16'o000015);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
